// File: rtl/mem_clear_pkg.sv
// Shared types for the post-probe memory clear sequencer.
// Engine state encodings and SDRAM size codes.
package mem_clear_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } sdr_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_BURST,
        D_DONE
    } ddr_state_t;

    localparam logic [1:0] SIZE_32MB  = 2'd0;
    localparam logic [1:0] SIZE_64MB  = 2'd1;
    localparam logic [1:0] SIZE_128MB = 2'd2;
    localparam logic [1:0] SIZE_RSVD  = 2'd3;

    // The reserved code behaves like the largest supported part.
    function automatic logic [1:0] size_clamp(input logic [1:0] code);
        return (code == SIZE_RSVD) ? SIZE_128MB : code;
    endfunction

endpackage

// File: rtl/mem_clear_seq_ddr.sv
// DDR3 burst clear engine: writes zero bursts across a fixed window.
// Address and beat count only move on accepted beats.
module ddr_burst_writer
    import mem_clear_pkg::*;
#(
    parameter logic [28:0] DDR_BASE  = 29'h0,
    parameter logic [28:0] DDR_WORDS = 29'h1000000,
    parameter int          DDR_BURST = 128
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        go,
    input  logic        busy_in,
    output logic [28:0] addr,
    output logic [7:0]  burstcnt,
    output logic [63:0] din,
    output logic [7:0]  be,
    output logic        we,
    output logic        done
);

    localparam logic [7:0]  BEATS     = 8'(DDR_BURST);
    localparam logic [28:0] STRIDE    = 29'(DDR_BURST);
    localparam logic [28:0] LAST_ADDR = DDR_BASE + DDR_WORDS - STRIDE;

    ddr_state_t state;
    ddr_state_t state_nx;
    logic [7:0] beat;
    logic       accept;
    logic       last_beat;
    logic       last_burst;

    assign accept     = we & ~busy_in;
    assign last_beat  = (beat == BEATS - 8'd1);
    assign last_burst = (addr == LAST_ADDR);

    always_ff @(posedge clk_sys) begin
        if (RESET) state <= D_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            D_IDLE:  if (go) state_nx = D_BURST;
            D_BURST: if (accept && last_beat && last_burst)
                         state_nx = D_DONE;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            addr <= '0;
            beat <= '0;
        end else if (state == D_IDLE && go) begin
            addr <= DDR_BASE;
            beat <= '0;
        end else if (accept) begin
            if (last_beat) begin
                beat <= '0;
                if (!last_burst) addr <= addr + STRIDE;
            end else begin
                beat <= beat + 8'd1;
            end
        end
    end

    always_comb begin
        we   = (state == D_BURST);
        done = (state == D_DONE);
    end

    assign burstcnt = BEATS;
    assign din      = '0;
    assign be       = 8'hFF;

endmodule

// File: rtl/mem_clear_seq.sv
// Zeroes SDRAM and DDR3 after the size probe; both engines run concurrently.
// One start edge per reset; the SDRAM engine lives here, DDR3 in a sub-module.
module mem_clear_seq
    import mem_clear_pkg::*;
#(
    parameter int          SDR_UNIT  = 2**24,
    parameter logic [28:0] DDR_BASE  = 29'h0,
    parameter logic [28:0] DDR_WORDS = 29'h1000000,
    parameter int          DDR_BURST = 128
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        start,
    input  logic [1:0]  size_code,
    input  logic        sdr_ready,
    output logic [25:0] sdr_addr,
    output logic [15:0] sdr_din,
    output logic        sdr_we,
    input  logic        ddr_busy,
    output logic [28:0] ddr_addr,
    output logic [7:0]  ddr_burstcnt,
    output logic [63:0] ddr_din,
    output logic [7:0]  ddr_be,
    output logic        ddr_we,
    output logic        busy,
    output logic        sdr_done,
    output logic        ddr_done
);

    localparam logic [26:0] UNIT = 27'(SDR_UNIT);

    sdr_state_t  state;
    sdr_state_t  state_nx;
    logic        start_q;
    logic        go;
    logic        go_seen;
    logic [1:0]  size_q;
    logic [26:0] words;
    logic [25:0] last_addr;
    logic        at_last;

    // DDR engine is idle exactly when it is neither bursting nor done.
    assign go = start & ~start_q & (state == S_IDLE)
              & ~ddr_we & ~ddr_done;

    // 27-bit count so the 128MB case reaches 2**26 words without wrapping.
    assign words     = UNIT << size_q;
    assign last_addr = 26'(words - 27'd1);
    assign at_last   = (sdr_addr == last_addr);

    always_ff @(posedge clk_sys) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (go) state_nx = S_ISSUE;
            S_ISSUE: if (sdr_ready) state_nx = S_HOLD;
            S_HOLD:  state_nx = at_last ? S_DONE : S_ISSUE;
            default: state_nx = state;
        endcase
    end

    always_comb begin
        sdr_we   = (state == S_ISSUE) & sdr_ready;
        sdr_done = (state == S_DONE);
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            start_q  <= 1'b0;
            go_seen  <= 1'b0;
            size_q   <= SIZE_32MB;
            sdr_addr <= '0;
        end else begin
            start_q <= start;
            if (go) begin
                go_seen  <= 1'b1;
                size_q   <= size_clamp(size_code);
                sdr_addr <= '0;
            end else if (state == S_HOLD && !at_last) begin
                sdr_addr <= sdr_addr + 26'd1;
            end
        end
    end

    assign sdr_din = '0;
    assign busy    = go_seen & ~(sdr_done & ddr_done);

    ddr_burst_writer #(
        .DDR_BASE  (DDR_BASE),
        .DDR_WORDS (DDR_WORDS),
        .DDR_BURST (DDR_BURST)
    ) u_ddr (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .go       (go),
        .busy_in  (ddr_busy),
        .addr     (ddr_addr),
        .burstcnt (ddr_burstcnt),
        .din      (ddr_din),
        .be       (ddr_be),
        .we       (ddr_we),
        .done     (ddr_done)
    );

endmodule

// File: tb/tb_mem_clear_seq.sv
// Bench for mem_clear_seq with small sim sizes and a queue-based model.
// A negedge monitor logs writes; scenario tasks compare against the model.
module tb_mem_clear_seq;

    localparam int          SDR_UNIT  = 16;
    localparam logic [28:0] DDR_BASE  = 29'h100;
    localparam logic [28:0] DDR_WORDS = 29'd32;
    localparam int          DDR_BURST = 8;

    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  size_code = 2'd0;
    logic        sdr_ready = 1'b1;
    logic        ddr_busy = 1'b0;
    logic [25:0] sdr_addr;
    logic [15:0] sdr_din;
    logic        sdr_we;
    logic [28:0] ddr_addr;
    logic [7:0]  ddr_burstcnt;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic        ddr_we;
    logic        busy;
    logic        sdr_done;
    logic        ddr_done;

    mem_clear_seq #(
        .SDR_UNIT  (SDR_UNIT),
        .DDR_BASE  (DDR_BASE),
        .DDR_WORDS (DDR_WORDS),
        .DDR_BURST (DDR_BURST)
    ) dut (
        .clk_sys      (clk_sys),
        .RESET        (RESET),
        .start        (start),
        .size_code    (size_code),
        .sdr_ready    (sdr_ready),
        .sdr_addr     (sdr_addr),
        .sdr_din      (sdr_din),
        .sdr_we       (sdr_we),
        .ddr_busy     (ddr_busy),
        .ddr_addr     (ddr_addr),
        .ddr_burstcnt (ddr_burstcnt),
        .ddr_din      (ddr_din),
        .ddr_be       (ddr_be),
        .ddr_we       (ddr_we),
        .busy         (busy),
        .sdr_done     (sdr_done),
        .ddr_done     (ddr_done)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sdr_a[$];
    int sdr_c[$];
    int ddr_a[$];
    int ddr_c[$];
    int done_cyc = -1;
    int viol_ready = 0;
    int viol_stall = 0;
    int viol_const = 0;
    logic        pw_we = 1'b0;
    logic        pw_busy = 1'b0;
    logic [28:0] p_addr = '0;

    always @(negedge clk_sys) begin
        cyc++;
        if (sdr_we === 1'b1) begin
            sdr_a.push_back(int'(sdr_addr));
            sdr_c.push_back(cyc);
            if (sdr_ready !== 1'b1) viol_ready++;
        end
        if (ddr_we === 1'b1 && ddr_busy === 1'b0) begin
            ddr_a.push_back(int'(ddr_addr));
            ddr_c.push_back(cyc);
        end
        if (ddr_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (ddr_burstcnt !== 8'd8 || ddr_be !== 8'hFF ||
            ddr_din !== 64'd0 || sdr_din !== 16'd0)
            viol_const++;
        if (pw_we && pw_busy &&
            (ddr_we !== 1'b1 || ddr_addr !== p_addr))
            viol_stall++;
        pw_we   = ddr_we;
        pw_busy = ddr_busy;
        p_addr  = ddr_addr;
    end

    // Model: SDRAM word count per size code, DDR beat address by index.
    function automatic int sdr_words(input int sc);
        return SDR_UNIT << ((sc > 2) ? 2 : sc);
    endfunction

    function automatic int ddr_beat_addr(input int i);
        return int'(DDR_BASE) + DDR_BURST * (i / DDR_BURST);
    endfunction

    task automatic clear_mon();
        sdr_a.delete();
        sdr_c.delete();
        ddr_a.delete();
        ddr_c.delete();
        done_cyc   = -1;
        viol_ready = 0;
        viol_stall = 0;
        viol_const = 0;
        pw_we      = 1'b0;
        pw_busy    = 1'b0;
    endtask

    task automatic step(input bit rnd);
        @(posedge clk_sys);
        #1;
        ddr_busy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_sys);
        #1;
        RESET     = 1'b1;
        start     = 1'b0;
        ddr_busy  = 1'b0;
        sdr_ready = 1'b1;
        @(posedge clk_sys);
        #1;
        RESET = 1'b0;
        clear_mon();
    endtask

    task automatic run_until_done(input int budget, input bit rnd,
                                  output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(rnd);
            if (sdr_done === 1'b1 && ddr_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        step(1'b0);
        step(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (sdr_we !== 1'b0 || sdr_addr !== 26'd0) begin
            bad++;
            $display("FAIL reset_sdr we=%0b addr=%0h want 0/0",
                     sdr_we, sdr_addr);
        end
        total++;
        if (ddr_we !== 1'b0 || ddr_addr !== 29'd0) begin
            bad++;
            $display("FAIL reset_ddr we=%0b addr=%0h want 0/0",
                     ddr_we, ddr_addr);
        end
        total++;
        if (ddr_burstcnt !== 8'd8 || ddr_be !== 8'hFF) begin
            bad++;
            $display("FAIL reset_const burstcnt=%0d be=%0h want 8/FF",
                     ddr_burstcnt, ddr_be);
        end
        total++;
        if (busy !== 1'b0 || sdr_done !== 1'b0 || ddr_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%0b sd=%0b dd=%0b want 0",
                     busy, sdr_done, ddr_done);
        end
    endtask

    task automatic test_clear(input int sc, input bit rnd);
        bit ok;
        int n;
        int m;
        int sp;
        int dm;
        n = sdr_words(sc);
        do_reset();
        size_code = 2'(sc);
        step(1'b0);
        start = 1'b1;
        step(rnd);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_start sc=%0d got %0b want 1", sc, busy);
        end
        run_until_done(2000, rnd, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL done_timeout sc=%0d got 0 want 1", sc);
        end
        total++;
        if (sdr_a.size() != n) begin
            bad++;
            $display("FAIL sdr_count sc=%0d got %0d want %0d",
                     sc, sdr_a.size(), n);
        end
        m = 0;
        sp = 0;
        foreach (sdr_a[i]) begin
            if (sdr_a[i] != i) m++;
            if (i > 0 && sdr_c[i] - sdr_c[i-1] != 2) sp++;
        end
        total++;
        if (m != 0 || sp != 0) begin
            bad++;
            $display("FAIL sdr_seq sc=%0d addr_err=%0d gap_err=%0d want 0",
                     sc, m, sp);
        end
        total++;
        if (ddr_a.size() != int'(DDR_WORDS)) begin
            bad++;
            $display("FAIL ddr_count sc=%0d rnd=%0b got %0d want %0d",
                     sc, rnd, ddr_a.size(), int'(DDR_WORDS));
        end
        dm = 0;
        foreach (ddr_a[i])
            if (ddr_a[i] != ddr_beat_addr(i)) dm++;
        total++;
        if (dm != 0 || viol_stall != 0) begin
            bad++;
            $display("FAIL ddr_addr sc=%0d addr_err=%0d stall_err=%0d want 0",
                     sc, dm, viol_stall);
        end
        total++;
        if (ddr_c.size() == 0 || done_cyc != ddr_c[ddr_c.size()-1] + 1) begin
            bad++;
            $display("FAIL ddr_done_time got %0d want last_accept+1", done_cyc);
        end
        total++;
        if (viol_const != 0) begin
            bad++;
            $display("FAIL ddr_const got %0d want 0 bad cycles", viol_const);
        end
        total++;
        if (busy !== 1'b0 || sdr_done !== 1'b1 || ddr_done !== 1'b1) begin
            bad++;
            $display("FAIL end_flags busy=%0b sd=%0b dd=%0b want 0/1/1",
                     busy, sdr_done, ddr_done);
        end
    endtask

    task automatic test_ready_stall();
        bit ok;
        int n0;
        int m;
        do_reset();
        size_code = 2'd0;
        step(1'b0);
        start = 1'b1;
        for (int i = 0; i < 200 && sdr_a.size() < 5; i++) step(1'b0);
        sdr_ready = 1'b0;
        n0 = sdr_a.size();
        for (int i = 0; i < 20; i++) step(1'b0);
        total++;
        if (sdr_a.size() != n0 || viol_ready != 0) begin
            bad++;
            $display("FAIL ready_low writes got %0d want %0d (viol=%0d)",
                     sdr_a.size(), n0, viol_ready);
        end
        sdr_ready = 1'b1;
        run_until_done(2000, 1'b0, ok);
        m = 0;
        foreach (sdr_a[i])
            if (sdr_a[i] != i) m++;
        total++;
        if (!ok || sdr_a.size() != 16 || m != 0) begin
            bad++;
            $display("FAIL ready_seq count=%0d err=%0d ok=%0b want 16/0/1",
                     sdr_a.size(), m, ok);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int m;
        do_reset();
        size_code = 2'd0;
        step(1'b0);
        start = 1'b1;
        for (int i = 0; i < 200 && sdr_a.size() < 7; i++) step(1'b0);
        RESET = 1'b1;
        step(1'b0);
        total++;
        if (sdr_we !== 1'b0 || ddr_we !== 1'b0 ||
            sdr_addr !== 26'd0 || ddr_addr !== 29'd0) begin
            bad++;
            $display("FAIL mid_reset we=%0b/%0b addr=%0h/%0h want 0",
                     sdr_we, ddr_we, sdr_addr, ddr_addr);
        end
        total++;
        if (busy !== 1'b0 || sdr_done !== 1'b0 || ddr_done !== 1'b0 ||
            ddr_burstcnt !== 8'd8 || ddr_be !== 8'hFF) begin
            bad++;
            $display("FAIL mid_reset_flags busy=%0b sd=%0b dd=%0b bc=%0d be=%0h",
                     busy, sdr_done, ddr_done, ddr_burstcnt, ddr_be);
        end
        RESET = 1'b0;
        start = 1'b0;
        clear_mon();
        step(1'b0);
        start = 1'b1;
        run_until_done(2000, 1'b0, ok);
        m = 0;
        foreach (sdr_a[i])
            if (sdr_a[i] != i) m++;
        total++;
        if (!ok || sdr_a.size() != 16 || m != 0 ||
            ddr_a.size() != int'(DDR_WORDS)) begin
            bad++;
            $display("FAIL rearm sdr=%0d err=%0d ddr=%0d want 16/0/32",
                     sdr_a.size(), m, ddr_a.size());
        end
    endtask

    task automatic test_restart_ignored();
        bit ok;
        int m;
        do_reset();
        size_code = 2'd0;
        step(1'b0);
        start = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0);
        start = 1'b0;
        step(1'b0);
        start = 1'b1;
        run_until_done(2000, 1'b0, ok);
        m = 0;
        foreach (sdr_a[i])
            if (sdr_a[i] != i) m++;
        total++;
        if (!ok || sdr_a.size() != 16 || m != 0 ||
            ddr_a.size() != int'(DDR_WORDS)) begin
            bad++;
            $display("FAIL busy_edge sdr=%0d err=%0d ddr=%0d want 16/0/32",
                     sdr_a.size(), m, ddr_a.size());
        end
        start = 1'b0;
        step(1'b0);
        start = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0);
        total++;
        if (sdr_a.size() != 16 || ddr_a.size() != int'(DDR_WORDS) ||
            busy !== 1'b0 || sdr_done !== 1'b1 || ddr_done !== 1'b1) begin
            bad++;
            $display("FAIL done_edge sdr=%0d ddr=%0d busy=%0b want 16/32/0",
                     sdr_a.size(), ddr_a.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_clear(0, 1'b0);
        test_clear(2, 1'b0);
        test_clear(3, 1'b0);
        test_clear(1, 1'b1);
        test_clear(0, 1'b1);
        test_ready_stall();
        test_reset_mid();
        test_restart_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
